dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: core port 0 and loader/debug port 1.
// Define DMEM_ARB_RR_EN for round-robin; the default build is fixed priority.
module dmem_arbiter #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [31:0]   addr0,
    input  logic [31:0]   wdata0,
    output logic          done0,
    output logic          err0,
    output logic [31:0]   rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [31:0]   addr1,
    input  logic [31:0]   wdata1,
    output logic          done1,
    output logic          err1,
    output logic [31:0]   rdata1,
    output logic          stall0,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        owner;
    logic        owner_nx;
    logic        grant;
    logic        any_req;
    logic        take;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        bad;
    logic        do_mem;
    logic        resp;
    logic [31:0] rsp_data;

    assign any_req = req0 | req1;
    assign take    = (state == IDLE) && any_req;

`ifdef DMEM_ARB_RR_EN
    logic rr_last;

    // On conflict the requester that did not win last time goes first.
    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~rr_last;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= 1'b1;
        end else if (take) begin
            rr_last <= grant;
        end
    end
`else
    always_comb begin
        grant = ~req0;
    end
`endif

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = ISSUE;
                    owner_nx = grant;
                end
            end
            ISSUE: begin
                state_nx = RESP;
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
        end
    end

    // Fields are captured once at grant; later changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (take) begin
            lat_we    <= grant ? we1 : we0;
            lat_addr  <= grant ? addr1 : addr0;
            lat_wdata <= grant ? wdata1 : wdata0;
        end
    end

    assign bad = (lat_addr[1:0] != 2'b00)
               || (lat_addr[31:AW+2] != '0);

    // rst gating keeps an aborted store from reaching the array.
    assign do_mem    = (state == ISSUE) && !bad && !rst;
    assign mem_en    = do_mem;
    assign mem_we    = do_mem & lat_we;
    assign mem_addr  = do_mem ? lat_addr[AW+1:2] : '0;
    assign mem_wdata = do_mem ? lat_wdata : '0;

    assign resp     = (state == RESP) && !rst;
    assign rsp_data = (lat_we || bad) ? 32'h0 : mem_rdata;

    assign done0  = resp && !owner;
    assign done1  = resp && owner;
    assign err0   = done0 && bad;
    assign err1   = done1 && bad;
    assign rdata0 = done0 ? rsp_data : 32'h0;
    assign rdata1 = done1 ? rsp_data : 32'h0;

    assign stall0 = req0 && !done0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a 1-cycle synchronous memory model.
// Works with or without DMEM_ARB_RR_EN defined.
module tb_dmem_arbiter;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [31:0]   addr0, wdata0, addr1, wdata1;
    logic          done0, err0, done1, err1, stall0;
    logic [31:0]   rdata0, rdata1;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    logic [31:0] mem [0:(1<<AW)-1];

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .done0(done0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .done1(done1), .err1(err1), .rdata1(rdata1),
        .stall0(stall0),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the next expectation.
    always @(negedge clk) begin
        if (done0 || done1) begin
            exp_t e;
            int   p;
            p = done1 ? 1 : 0;
            chk("one_done", {31'b0, done0 & done1}, 32'h0);
            if (sb.size() == 0) begin
                chk("unexpected_done_port", p, 99);
            end else begin
                e = sb.pop_front();
                chk("done_port", p, e.port);
                chk("err", {31'b0, p ? err1 : err0}, {31'b0, e.err});
                chk("rdata", p ? rdata1 : rdata0, e.rdata);
            end
        end
    end

    task automatic drive(input int k, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (k == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // Single access on an idle arbiter: grant at N, issue N+1, done N+2.
    task automatic access(input int k, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic xerr,
                          input logic [31:0] xrd);
        sb.push_back('{k, xerr, xrd});
        drive(k, 1'b1, w, a, d);
        @(negedge clk);
        if (k == 0) chk("stall_n", {31'b0, stall0}, 32'h1);
        chk("mem_en_idle", {31'b0, mem_en}, 32'h0);
        @(negedge clk);
        if (k == 0) chk("stall_n1", {31'b0, stall0}, 32'h1);
        chk("mem_en_issue", {31'b0, mem_en}, {31'b0, !xerr});
        if (!xerr) begin
            chk("mem_addr", {24'b0, mem_addr}, {24'b0, a[9:2]});
            chk("mem_we", {31'b0, mem_we}, {31'b0, w});
        end
        @(negedge clk);
        chk("done_at_n2", {31'b0, k ? done1 : done0}, 32'h1);
        if (k == 0) chk("stall_n2", {31'b0, stall0}, 32'h0);
        @(posedge clk); #1;
        drive(k, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_done0", {31'b0, done0}, 32'h0);
        chk("rst_done1", {31'b0, done1}, 32'h0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst_mem_addr", {24'b0, mem_addr}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_stall0", {31'b0, stall0}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        do_reset();

        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        access(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        access(1, 1'b1, 32'h40, 32'h12345678, 1'b0, 32'h0);
        access(0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h12345678);
        access(1, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0);
        access(1, 1'b1, 32'h400, 32'h77, 1'b1, 32'h0);
        access(1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0);
        access(0, 1'b1, 32'h20, 32'hAAAA5555, 1'b0, 32'h0);

        // Reset during ISSUE of a store.
        drive(0, 1'b1, 1'b1, 32'h20, 32'h5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mem_en", {31'b0, mem_en}, 32'h0);
        chk("abort_mem_we", {31'b0, mem_we}, 32'h0);
        chk("abort_done0", {31'b0, done0}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("abort_no_done", {31'b0, done0}, 32'h0);
        @(posedge clk); #1;
        access(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'hAAAA5555);

        // Stall timing with req1 arriving one cycle late.
        sb.push_back('{0, 1'b0, 32'h12345678});
        sb.push_back('{1, 1'b0, 32'hDEADBEEF});
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        chk("st_n", {31'b0, stall0}, 32'h1);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("st_n1", {31'b0, stall0}, 32'h1);
        chk("st_issue0", {31'b0, mem_en}, 32'h1);
        @(negedge clk);
        chk("st_n2", {31'b0, stall0}, 32'h0);
        chk("st_done0", {31'b0, done0}, 32'h1);
        chk("st_done1_low", {31'b0, done1}, 32'h0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("st_n3_en", {31'b0, mem_en}, 32'h0);
        @(negedge clk);
        chk("st_n4_en", {31'b0, mem_en}, 32'h1);
        chk("st_n4_addr", {24'b0, mem_addr}, 32'h4);
        @(negedge clk);
        chk("st_n5_done1", {31'b0, done1}, 32'h1);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Conflict with both requests held for four grants.
        do_reset();
        for (int g = 0; g < 4; g++) begin
`ifdef DMEM_ARB_RR_EN
            if (g % 2 == 0) sb.push_back('{0, 1'b0, 32'h12345678});
            else sb.push_back('{1, 1'b0, 32'hDEADBEEF});
`else
            sb.push_back('{0, 1'b0, 32'h12345678});
`endif
        end
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
        repeat (12) @(negedge clk);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
